order_book_quoter: RTL and testbench
====================================

Name: order_book_quoter

Overview:
- Parametrised next-generation market-making engine.
- Consumes sequenced add-order messages and maintains a per-price-level bid/ask quantity book plus best bid/ask.
- Quotes one tick (EDGE) inside the spread. Fills any incoming order that crosses its quote, subject to a position limit.
- Reports each fill on a valid/ready trade port feeding the UART/LED reporting path. Adds message backpressure, sequence-gap recovery and range checking.

Parameters:
- NUM_LEVELS, 100: number of booked price levels.
- PRICE_BASE, 50: price mapped to level index 0.
- EDGE, 1: quote offset inside best bid/ask.
- POS_LIMIT, 1000: maximum absolute signed position.
- INIT_BALANCE, 100000: balance loaded at reset.

Ports:
- low_clk, in, 1: clock.
- rst, in, 1: reset.
- msg, in, 168: message. [7:0] type (0 = add order), [39:8] seq, [47:40] side (0 = bid, else ask), [111:80] price, [143:112] qty.
- msg_valid, in, 1: msg present.
- msg_ready, out, 1: block can accept msg.
- trade_valid, out, 1: fill pending.
- trade_ready, in, 1: consumer accepts fill.
- trade_side, out, 1: 0 = we bought, 1 = we sold.
- trade_price, out, 32: fill price.
- trade_qty, out, 32: fill quantity.
- balance, out, 32: signed cash.
- position, out, 32: signed stock held.
- best_bid, out, 32: highest booked bid price (0 = none).
- best_ask, out, 32: lowest booked ask price (all-ones = none).
- gap_err, out, 1: sticky sequence-gap flag.
- drop_cnt, out, 16: out-of-range messages discarded.

Behaviour:
- Reset rst is synchronous and active-high; clock is low_clk.
- Reset values:
  - state IDLE, msg_ready 1, trade_valid 0.
  - trade_side/price/qty 0.
  - balance INIT_BALANCE, position 0.
  - best_bid 0, best_ask all-ones, expected seq 0.
  - gap_err 0, drop_cnt 0, all level quantities 0.
- Reset mid-operation discards any held message or pending fill. It takes priority over all other logic.
- State machine: IDLE -> APPLY -> (EMIT | IDLE); EMIT -> IDLE.
- IDLE:
  - msg_ready = 1.
  - On msg_valid, register msg and go to APPLY.
- APPLY (msg_ready = 0), sequence check on the registered msg:
  - seq < expected: duplicate. No effect, return to IDLE.
  - seq > expected: set gap_err, then process as if in sequence.
  - In all processed cases expected := seq + 1, wrapping at 2^32.
  - Type != 0: consumes seq only, no other effect.
- Add order, side 0 (incoming bid):
  - Crosses if price >= best_ask - EDGE and position - qty >= -POS_LIMIT.
  - On cross: position -= qty; balance += price*qty (product truncated to 32 bits, two's-complement wrap); trade_side 1.
- Add order, side 1 (incoming ask):
  - Crosses if price <= best_bid + EDGE and position + qty <= POS_LIMIT.
  - On cross: position += qty; balance -= price*qty; trade_side 0.
- On a cross:
  - Latch trade_price/trade_qty and assert trade_valid on the next cycle; go to EMIT.
  - The order is not booked.
- No cross:
  - If PRICE_BASE <= price < PRICE_BASE + NUM_LEVELS, add qty to that side's level, saturating at 2^32 - 1.
  - Update best_bid if price > best_bid (bid side), or best_ask if price < best_ask (ask side). Return to IDLE.
  - Out-of-range price: not booked, best prices unchanged, drop_cnt += 1 (saturates at 0xFFFF).
- Limit-blocked crosses fall through to the no-cross path.
- EMIT:
  - msg_ready = 0.
  - trade_valid and trade_* stay stable until trade_ready is sampled high, then trade_valid 0 and go to IDLE.
- Latency: message accepted at edge N -> book/balance updated at edge N+1 -> trade_valid visible after edge N+1.
- Peak throughput is 1 message per 2 cycles.
- Compare width is 32-bit unsigned for prices. The best_ask - EDGE and best_bid + EDGE computations wrap.
- With an empty ask book, best_ask - EDGE stays very large, so a bid effectively never crosses.

Test Plan:
- Reset, then seq 0 bid px 60 qty 5 -> level bid[10] = 5, best_bid 60, no trade, msg_ready low exactly 1 cycle.
- Then seq 1 ask px 61 qty 3 (<= 60 + 1) -> trade_valid 1 cycle after APPLY, side 0, price 61, qty 3, position 3, balance 99817.
- Hold trade_ready 0 for 4 cycles with msg_valid high -> trade fields stable, msg_ready 0 throughout, no msg consumed; release -> returns to IDLE.
- Seq 5 arrives when expected is 2 -> gap_err 1, message processed, expected 6; then seq 3 -> ignored, no state change.
- POS_LIMIT = 4, position 3, ask px 55 qty 2 with best_bid 60 -> no fill, booked at ask[5], best_ask 55.
- Bid px 200 non-crossing -> drop_cnt 1, book unchanged; assert rst while trade_valid high -> trade_valid 0, balance 100000 next cycle.

Source files
------------

// File: rtl/order_book_quoter.sv
// Market-making quoter: books sequenced add-orders per price level and quotes EDGE inside the spread.
// Crossing orders are filled within a position limit; each fill is reported over a valid/ready trade port.
module order_book_quoter #(
  parameter int NUM_LEVELS   = 100,
  parameter int PRICE_BASE   = 50,
  parameter int EDGE         = 1,
  parameter int POS_LIMIT    = 1000,
  parameter int INIT_BALANCE = 100000
) (
  input  logic         low_clk,
  input  logic         rst,
  input  logic [167:0] msg,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic         trade_valid,
  input  logic         trade_ready,
  output logic         trade_side,
  output logic [31:0]  trade_price,
  output logic [31:0]  trade_qty,
  output logic [31:0]  balance,
  output logic [31:0]  position,
  output logic [31:0]  best_bid,
  output logic [31:0]  best_ask,
  output logic         gap_err,
  output logic [15:0]  drop_cnt
);

  localparam int IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam logic [31:0] BASE_PX = 32'(PRICE_BASE);
  localparam logic [31:0] TOP_PX  = 32'(PRICE_BASE + NUM_LEVELS);
  localparam logic [31:0] EDGE_PX = 32'(EDGE);
  localparam logic signed [33:0] POS_HI = 34'(POS_LIMIT);
  localparam logic signed [33:0] POS_LO = -POS_HI;

  typedef enum logic [1:0] {IDLE, APPLY, EMIT} state_t;

  state_t state, next_state;

  // Held copy of the accepted message.
  logic [7:0]  m_type;
  logic [31:0] m_seq;
  logic        m_side;
  logic [31:0] m_price;
  logic [31:0] m_qty;

  logic [31:0] exp_seq;
  logic [31:0] bid_qty [NUM_LEVELS];
  logic [31:0] ask_qty [NUM_LEVELS];

  logic                    is_dup, is_gap, is_add, in_range;
  logic                    bid_cross, ask_cross, do_fill;
  logic [IDX_W-1:0]        lvl_idx;
  logic signed [33:0]      pos_wide, qty_wide;
  logic [31:0]             notional, ask_thresh, bid_thresh;
  logic [32:0]             bid_sum, ask_sum;

  logic unused_msg_bits;
  assign unused_msg_bits = ^{msg[167:144], msg[79:48]};

  always_comb begin
    is_dup     = (m_seq < exp_seq);
    is_gap     = (m_seq > exp_seq);
    is_add     = (m_type == 8'd0);
    pos_wide   = {{2{position[31]}}, position};
    qty_wide   = {2'b00, m_qty};
    ask_thresh = best_ask - EDGE_PX;
    bid_thresh = best_bid + EDGE_PX;
    // Incoming bid lifts our offer; incoming ask hits our bid.
    bid_cross  = (m_price >= ask_thresh) && ((pos_wide - qty_wide) >= POS_LO);
    ask_cross  = (m_price <= bid_thresh) && ((pos_wide + qty_wide) <= POS_HI);
    do_fill    = !is_dup && is_add && (m_side ? ask_cross : bid_cross);
    in_range   = (m_price >= BASE_PX) && (m_price < TOP_PX);
    lvl_idx    = IDX_W'(m_price - BASE_PX);
    bid_sum    = {1'b0, bid_qty[lvl_idx]} + {1'b0, m_qty};
    ask_sum    = {1'b0, ask_qty[lvl_idx]} + {1'b0, m_qty};
    notional   = m_price * m_qty;
  end

  always_ff @(posedge low_clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    msg_ready   = 1'b0;
    trade_valid = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) next_state = APPLY;
      end
      APPLY:   next_state = do_fill ? EMIT : IDLE;
      EMIT: begin
        trade_valid = 1'b1;
        if (trade_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge low_clk) begin
    if (rst) begin
      m_type      <= '0;
      m_seq       <= '0;
      m_side      <= 1'b0;
      m_price     <= '0;
      m_qty       <= '0;
      exp_seq     <= '0;
      trade_side  <= 1'b0;
      trade_price <= '0;
      trade_qty   <= '0;
      balance     <= 32'(INIT_BALANCE);
      position    <= '0;
      best_bid    <= '0;
      best_ask    <= '1;
      gap_err     <= 1'b0;
      drop_cnt    <= '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        bid_qty[i] <= '0;
        ask_qty[i] <= '0;
      end
    end else begin
      if (state == IDLE && msg_valid) begin
        m_type  <= msg[7:0];
        m_seq   <= msg[39:8];
        m_side  <= |msg[47:40];
        m_price <= msg[111:80];
        m_qty   <= msg[143:112];
      end
      if (state == APPLY && !is_dup) begin
        exp_seq <= m_seq + 32'd1;
        if (is_gap) gap_err <= 1'b1;
        if (is_add) begin
          if (do_fill) begin
            trade_price <= m_price;
            trade_qty   <= m_qty;
            if (m_side) begin
              trade_side <= 1'b0;
              position   <= position + m_qty;
              balance    <= balance - notional;
            end else begin
              trade_side <= 1'b1;
              position   <= position - m_qty;
              balance    <= balance + notional;
            end
          end else if (in_range) begin
            if (m_side) begin
              ask_qty[lvl_idx] <= ask_sum[32] ? '1 : ask_sum[31:0];
              if (m_price < best_ask) best_ask <= m_price;
            end else begin
              bid_qty[lvl_idx] <= bid_sum[32] ? '1 : bid_sum[31:0];
              if (m_price > best_bid) best_bid <= m_price;
            end
          end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_order_book_quoter.sv
// Directed plus randomized bench for order_book_quoter against a plain-arithmetic order-book model.
module tb_order_book_quoter;

  localparam int NL = 100;
  localparam int PB = 50;
  localparam int ED = 1;
  localparam int PL = 4;
  localparam int IB = 100000;

  logic         low_clk = 1'b0;
  logic         rst = 1'b1;
  logic [167:0] msg = '0;
  logic         msg_valid = 1'b0;
  logic         trade_ready = 1'b0;
  logic         msg_ready, trade_valid, trade_side, gap_err;
  logic [31:0]  trade_price, trade_qty, balance, position, best_bid, best_ask;
  logic [15:0]  drop_cnt;

  order_book_quoter #(
    .NUM_LEVELS(NL), .PRICE_BASE(PB), .EDGE(ED), .POS_LIMIT(PL), .INIT_BALANCE(IB)
  ) dut (
    .low_clk(low_clk), .rst(rst), .msg(msg), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .trade_valid(trade_valid), .trade_ready(trade_ready), .trade_side(trade_side),
    .trade_price(trade_price), .trade_qty(trade_qty), .balance(balance), .position(position),
    .best_bid(best_bid), .best_ask(best_ask), .gap_err(gap_err), .drop_cnt(drop_cnt)
  );

  always #5 low_clk = ~low_clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_bal, m_pos, m_bb, m_ba, m_exp, m_tpx, m_tqty;
  bit          m_gap, m_tside;
  int          m_drop;
  longint      m_bid [NL];
  longint      m_ask [NL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bal = 32'(IB); m_pos = '0; m_bb = '0; m_ba = '1; m_exp = '0;
    m_gap = 0; m_drop = 0; m_tside = 0; m_tpx = '0; m_tqty = '0;
    for (int i = 0; i < NL; i++) begin
      m_bid[i] = 0;
      m_ask[i] = 0;
    end
  endtask

  function automatic logic [167:0] mk(input logic [7:0] typ, input logic [31:0] seq, input bit side,
                                      input logic [31:0] px, input logic [31:0] qty);
    logic [7:0] sb;
    sb = side ? 8'($urandom_range(1, 255)) : 8'd0;
    return {24'($urandom), qty, px, 32'($urandom), sb, seq, typ};
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".bal"}, balance, m_bal);
    check({tag, ".pos"}, position, m_pos);
    check({tag, ".bb"}, best_bid, m_bb);
    check({tag, ".ba"}, best_ask, m_ba);
    check({tag, ".gap"}, 32'(gap_err), 32'(m_gap));
    check({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    check({tag, ".tside"}, 32'(trade_side), 32'(m_tside));
    check({tag, ".tpx"}, trade_price, m_tpx);
    check({tag, ".tqty"}, trade_qty, m_tqty);
  endtask

  task automatic check_level(input string tag, input bit side, input int idx);
    if (side) check({tag, ".ask_lvl"}, dut.ask_qty[idx], 32'(m_ask[idx]));
    else      check({tag, ".bid_lvl"}, dut.bid_qty[idx], 32'(m_bid[idx]));
  endtask

  task automatic send(input string tag, input logic [7:0] typ, input logic [31:0] seq, input bit side,
                      input logic [31:0] px, input logic [31:0] qty, input int hold);
    bit     fill, booked;
    int     idx, n;
    logic [31:0] thr;
    longint pnew;
    fill = 0; booked = 0; idx = 0; n = 0;
    while (msg_ready !== 1'b1 && n < 20) begin
      @(posedge low_clk); #1;
      n++;
    end
    check({tag, ".rdy_idle"}, 32'(msg_ready), 32'd1);
    msg = mk(typ, seq, side, px, qty);
    msg_valid = 1'b1;
    @(posedge low_clk); #1;
    msg_valid = 1'b0;
    check({tag, ".rdy_apply"}, 32'(msg_ready), 32'd0);
    check({tag, ".tv_apply"}, 32'(trade_valid), 32'd0);

    if (seq >= m_exp) begin
      if (seq > m_exp) m_gap = 1;
      m_exp = seq + 32'd1;
      if (typ == 8'd0) begin
        if (!side) begin
          thr  = m_ba - 32'(ED);
          pnew = longint'($signed(m_pos)) - longint'(qty);
          fill = (px >= thr) && (pnew >= -PL);
        end else begin
          thr  = m_bb + 32'(ED);
          pnew = longint'($signed(m_pos)) + longint'(qty);
          fill = (px <= thr) && (pnew <= PL);
        end
        if (fill) begin
          m_pos   = side ? m_pos + qty : m_pos - qty;
          m_bal   = side ? m_bal - px * qty : m_bal + px * qty;
          m_tside = !side;
          m_tpx   = px;
          m_tqty  = qty;
        end else if (px >= 32'(PB) && px < 32'(PB + NL)) begin
          booked = 1;
          idx = int'(px) - PB;
          if (!side) begin
            m_bid[idx] = m_bid[idx] + longint'(qty);
            if (m_bid[idx] > longint'(32'hFFFF_FFFF)) m_bid[idx] = longint'(32'hFFFF_FFFF);
            if (px > m_bb) m_bb = px;
          end else begin
            m_ask[idx] = m_ask[idx] + longint'(qty);
            if (m_ask[idx] > longint'(32'hFFFF_FFFF)) m_ask[idx] = longint'(32'hFFFF_FFFF);
            if (px < m_ba) m_ba = px;
          end
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end

    @(posedge low_clk); #1;
    check({tag, ".tv"}, 32'(trade_valid), 32'(fill));
    if (fill) begin
      for (int k = 0; k < hold; k++) begin
        msg = mk(8'd0, m_exp, 1'b0, 32'd70, 32'd1);
        msg_valid = 1'b1;
        check({tag, ".hold_rdy"}, 32'(msg_ready), 32'd0);
        check({tag, ".hold_tv"}, 32'(trade_valid), 32'd1);
        check({tag, ".hold_px"}, trade_price, m_tpx);
        check({tag, ".hold_qty"}, trade_qty, m_tqty);
        @(posedge low_clk); #1;
      end
      check({tag, ".tv_held"}, 32'(trade_valid), 32'd1);
      msg_valid = 1'b0;
      trade_ready = 1'b1;
      @(posedge low_clk); #1;
      trade_ready = 1'b0;
      check({tag, ".tv_done"}, 32'(trade_valid), 32'd0);
    end
    check({tag, ".rdy_done"}, 32'(msg_ready), 32'd1);
    check_state(tag);
    if (booked) check_level(tag, side, idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge low_clk);
    #1;
    check("rst.rdy", 32'(msg_ready), 32'd1);
    check("rst.tv", 32'(trade_valid), 32'd0);
    check_state("rst");
    check_level("rst", 1'b0, 10);
    rst = 1'b0;
    @(posedge low_clk); #1;

    send("s0_bid60", 8'd0, 32'd0, 1'b0, 32'd60, 32'd5, 0);
    send("s1_ask61", 8'd0, 32'd1, 1'b1, 32'd61, 32'd3, 4);
    send("s5_gap", 8'd0, 32'd5, 1'b0, 32'd58, 32'd2, 0);
    send("s3_dup", 8'd0, 32'd3, 1'b1, 32'd50, 32'd1, 0);
    send("s6_limit", 8'd0, 32'd6, 1'b1, 32'd55, 32'd2, 0);
    send("s7_range", 8'd0, 32'd7, 1'b0, 32'd200, 32'd10, 0);
    send("s8_type", 8'd3, 32'd8, 1'b1, 32'd52, 32'd1, 0);
    send("s9_big", 8'd0, 32'd9, 1'b0, 32'd51, 32'hFFFF_FFF0, 0);
    send("s10_sat", 8'd0, 32'd10, 1'b0, 32'd51, 32'h0000_0100, 0);

    // Reset while a fill is pending.
    msg = mk(8'd0, 32'd11, 1'b1, 32'd52, 32'd1);
    msg_valid = 1'b1;
    @(posedge low_clk); #1;
    msg_valid = 1'b0;
    @(posedge low_clk); #1;
    check("rstfill.tv_before", 32'(trade_valid), 32'd1);
    rst = 1'b1;
    @(posedge low_clk); #1;
    model_reset();
    check("rstfill.tv", 32'(trade_valid), 32'd0);
    check("rstfill.rdy", 32'(msg_ready), 32'd1);
    check_state("rstfill");
    check_level("rstfill", 1'b0, 10);
    check_level("rstfill", 1'b1, 5);
    rst = 1'b0;
    @(posedge low_clk); #1;

    for (int i = 0; i < 200; i++) begin
      int r;
      logic [31:0] q;
      r = int'($urandom_range(0, 9));
      if (r == 0 && m_exp >= 32'd3) seq = m_exp - 32'd1 - 32'($urandom_range(0, 2));
      else if (r == 1) seq = m_exp + 32'($urandom_range(1, 3));
      else seq = m_exp;
      q = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h8000_0000) : 32'($urandom_range(1, 3));
      send("rnd", ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, seq,
           1'($urandom_range(0, 1)), 32'($urandom_range(40, 160)), q, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
